// File: rtl/hit_scorer_pkg.sv
// Shared definitions for the hit scorer: VGA timing, scoring defaults and FSM encoding.
// The timing constants are the same ones the VGA logic and the drawers use.
package hit_scorer_pkg;

    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int MIN_OVERLAP = 4;
    localparam int SHOT_FRAMES = 30;
    localparam int KILL_FRAMES = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        KILL  = 2'd2
    } state_t;

    // Counters in this block stick at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hit_scorer_if.sv
// Pixel-side inputs and scoring outputs of the hit scorer, bundled as one port.
// The master side is the VGA/drawer pipeline, the slave side is the scorer.
interface hit_scorer_if;

    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       duck_draw;
    logic       shot_draw;
    logic       fire;

    logic       armed;
    logic       hit_pulse;
    logic       miss_pulse;
    logic       duck_kill;
    logic [7:0] score;
    logic [7:0] shots;

    modport master (
        output hcount, vcount, duck_draw, shot_draw, fire,
        input  armed, hit_pulse, miss_pulse, duck_kill, score, shots
    );

    modport slave (
        input  hcount, vcount, duck_draw, shot_draw, fire,
        output armed, hit_pulse, miss_pulse, duck_kill, score, shots
    );

endinterface

// File: rtl/hit_scorer_fire_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// A raw low-to-high edge produces a one-cycle rise three clocks later.
module hit_scorer_fire_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic       rise_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            prev_reg <= sync_reg[1];
            // Bounce after synchronisation still yields one rise per 0->1 step.
            rise_reg <= sync_reg[1] & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/hit_scorer.sv
// Per-frame hit decision: counts duck/shot overlap in the visible area and
// scores an armed shot at the end of each frame, driving the falling-duck state.
module hit_scorer #(
    parameter int H_TOTAL     = hit_scorer_pkg::H_TOTAL,
    parameter int V_TOTAL     = hit_scorer_pkg::V_TOTAL,
    parameter int H_ACTIVE    = hit_scorer_pkg::H_ACTIVE,
    parameter int V_ACTIVE    = hit_scorer_pkg::V_ACTIVE,
    parameter int MIN_OVERLAP = hit_scorer_pkg::MIN_OVERLAP,
    parameter int SHOT_FRAMES = hit_scorer_pkg::SHOT_FRAMES,
    parameter int KILL_FRAMES = hit_scorer_pkg::KILL_FRAMES
) (
    input  logic         vga_clk,
    input  logic         reset,
    hit_scorer_if.slave  bus
);

    import hit_scorer_pkg::*;

    logic fire_rise;
    logic frame_end;
    logic pixel_overlap;

    state_t     state_reg, state_next;
    logic [7:0] ovl_reg, ovl_next;
    logic [7:0] frame_cnt_reg, frame_cnt_next;
    logic [7:0] kill_cnt_reg, kill_cnt_next;
    logic [7:0] score_reg, score_next;
    logic [7:0] shots_reg, shots_next;
    logic       hit_reg, hit_next;
    logic       miss_reg, miss_next;
    logic       arm_clear;

    hit_scorer_fire_edge_sync u_fire_sync (
        .clk   (vga_clk),
        .reset (reset),
        .din   (bus.fire),
        .rise  (fire_rise)
    );

    // The last pixel of the frame sits in blanking, so it never adds overlap.
    assign frame_end = (bus.hcount == 10'(H_TOTAL - 1)) &&
                       (bus.vcount == 10'(V_TOTAL - 1));

    assign pixel_overlap = (bus.hcount < 10'(H_ACTIVE)) &&
                           (bus.vcount < 10'(V_ACTIVE)) &&
                           bus.duck_draw && bus.shot_draw;

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        kill_cnt_next  = kill_cnt_reg;
        score_next     = score_reg;
        shots_next     = shots_reg;
        hit_next       = 1'b0;
        miss_next      = 1'b0;
        arm_clear      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (fire_rise) begin
                    state_next     = ARMED;
                    frame_cnt_next = 8'd0;
                    shots_next     = sat_inc(shots_reg);
                    arm_clear      = 1'b1;
                end
            end

            ARMED: begin
                if (frame_end) begin
                    if (ovl_reg >= 8'(MIN_OVERLAP)) begin
                        state_next    = KILL;
                        hit_next      = 1'b1;
                        score_next    = sat_inc(score_reg);
                        kill_cnt_next = 8'd0;
                    end else if (frame_cnt_reg == 8'(SHOT_FRAMES - 1)) begin
                        state_next = IDLE;
                        miss_next  = 1'b1;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 8'd1;
                    end
                end
            end

            KILL: begin
                if (frame_end) begin
                    if (kill_cnt_reg == 8'(KILL_FRAMES - 1)) begin
                        state_next = IDLE;
                    end else begin
                        kill_cnt_next = kill_cnt_reg + 8'd1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Arming restarts the count even if the arm lands on an overlapping pixel.
    always_comb begin
        ovl_next = ovl_reg;
        if (arm_clear) begin
            ovl_next = 8'd0;
        end else if (frame_end) begin
            ovl_next = 8'd0;
        end else if (pixel_overlap) begin
            ovl_next = sat_inc(ovl_reg);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ovl_reg       <= 8'd0;
            frame_cnt_reg <= 8'd0;
            kill_cnt_reg  <= 8'd0;
            score_reg     <= 8'd0;
            shots_reg     <= 8'd0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ovl_reg       <= ovl_next;
            frame_cnt_reg <= frame_cnt_next;
            kill_cnt_reg  <= kill_cnt_next;
            score_reg     <= score_next;
            shots_reg     <= shots_next;
            hit_reg       <= hit_next;
            miss_reg      <= miss_next;
        end
    end

    assign bus.armed      = (state_reg == ARMED);
    assign bus.duck_kill  = (state_reg == KILL);
    assign bus.hit_pulse  = hit_reg;
    assign bus.miss_pulse = miss_reg;
    assign bus.score      = score_reg;
    assign bus.shots      = shots_reg;

endmodule

// File: tb/tb_hit_scorer.sv
// Directed bench for hit_scorer on a 16x8 frame; a second instance on an 8x4
// frame with one kill frame reaches score/shots saturation quickly.
module tb_hit_scorer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hit_scorer_if m ();
    hit_scorer_if s ();

    hit_scorer #(
        .H_TOTAL(16), .V_TOTAL(8), .H_ACTIVE(12), .V_ACTIVE(6),
        .MIN_OVERLAP(4), .SHOT_FRAMES(3), .KILL_FRAMES(2)
    ) dut (
        .vga_clk (clk),
        .reset   (rst),
        .bus     (m)
    );

    hit_scorer #(
        .H_TOTAL(8), .V_TOTAL(4), .H_ACTIVE(6), .V_ACTIVE(3),
        .MIN_OVERLAP(4), .SHOT_FRAMES(3), .KILL_FRAMES(1)
    ) dut_sat (
        .vga_clk (clk),
        .reset   (rst),
        .bus     (s)
    );

    int hc, vc, sh, sv;
    int plan;
    bit draw_blank;
    int nvec, nerr;
    int hits_seen, misses_seen, both_seen;
    int kc, g, sat_timeouts;

    task automatic drive();
        logic dd;
        dd = draw_blank ? ((hc >= 12) || (vc >= 6)) : ((vc * 16 + hc) < plan);
        m.hcount    = 10'(hc);
        m.vcount    = 10'(vc);
        m.duck_draw = dd;
        m.shot_draw = dd;
        s.hcount    = 10'(sh);
        s.vcount    = 10'(sv);
        s.duck_draw = 1'b1;
        s.shot_draw = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m.hit_pulse === 1'b1) hits_seen++;
        if (m.miss_pulse === 1'b1) misses_seen++;
        if (m.hit_pulse === 1'b1 && m.miss_pulse === 1'b1) both_seen++;
        hc = (hc == 15) ? 0 : hc + 1;
        if (hc == 0) vc = (vc == 7) ? 0 : vc + 1;
        sh = (sh == 7) ? 0 : sh + 1;
        if (sh == 0) sv = (sv == 3) ? 0 : sv + 1;
        drive();
    endtask

    // Advance until the frame_end pixel has been clocked in; outputs then show its effect.
    task automatic past_frame_end();
        while (!(hc == 15 && vc == 7)) tick();
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        hits_seen = 0; misses_seen = 0; both_seen = 0; sat_timeouts = 0;
        hc = 0; vc = 0; sh = 0; sv = 0;
        plan = 0; draw_blank = 1'b0;
        rst = 1'b1;
        m.fire = 1'b0;
        s.fire = 1'b0;
        drive();

        // Reset state
        repeat (3) tick();
        chk("rst_armed", m.armed, 0);
        chk("rst_kill", m.duck_kill, 0);
        chk("rst_hit", m.hit_pulse, 0);
        chk("rst_miss", m.miss_pulse, 0);
        chk("rst_score", m.score, 0);
        chk("rst_shots", m.shots, 0);
        rst = 1'b0;

        // Overlap while idle never scores
        plan = 128; drive();
        past_frame_end(); past_frame_end(); past_frame_end();
        chk("idle_hits", hits_seen, 0);
        chk("idle_misses", misses_seen, 0);
        chk("idle_score", m.score, 0);
        chk("idle_shots", m.shots, 0);
        chk("idle_armed", m.armed, 0);
        plan = 0; drive();

        // Hit: arm latency, ignored fire while armed, 5 overlaps in next frame
        m.fire = 1'b1; tick(); tick(); m.fire = 1'b0; tick();
        chk("arm_latency_early", m.armed, 0);
        tick();
        chk("arm_latency", m.armed, 1);
        chk("arm_shots", m.shots, 1);
        m.fire = 1'b1; tick(); tick(); m.fire = 1'b0;
        repeat (4) tick();
        chk("fire_in_armed_shots", m.shots, 1);
        past_frame_end();
        chk("partial_frame_armed", m.armed, 1);
        chk("partial_frame_hit", m.hit_pulse, 0);
        plan = 5; drive();
        past_frame_end();
        chk("hit_pulse", m.hit_pulse, 1);
        chk("hit_score", m.score, 1);
        chk("hit_shots", m.shots, 1);
        chk("hit_kill", m.duck_kill, 1);
        chk("hit_armed", m.armed, 0);
        plan = 0; drive();
        tick();
        chk("hit_one_cycle", m.hit_pulse, 0);
        kc = 2;
        for (int i = 0; i < 1000; i++) begin
            m.fire = (i == 10 || i == 11);
            tick();
            if (m.duck_kill !== 1'b1) break;
            kc++;
        end
        m.fire = 1'b0;
        chk("kill_cycles", kc, 256);
        chk("fire_in_kill_shots", m.shots, 1);
        chk("after_kill_armed", m.armed, 0);

        // Fire in idle after kill, then 3 overlaps per frame stays below threshold
        plan = 3; drive();
        m.fire = 1'b1; tick(); tick(); m.fire = 1'b0; tick(); tick();
        chk("rearm_armed", m.armed, 1);
        chk("rearm_shots", m.shots, 2);
        past_frame_end();
        chk("thr_f1_armed", m.armed, 1);
        chk("thr_f1_hit", m.hit_pulse, 0);
        past_frame_end();
        chk("thr_f2_armed", m.armed, 1);
        chk("thr_f2_miss", m.miss_pulse, 0);
        past_frame_end();
        chk("thr_miss", m.miss_pulse, 1);
        chk("thr_hit", m.hit_pulse, 0);
        chk("thr_armed", m.armed, 0);
        chk("thr_score", m.score, 1);
        tick();
        chk("miss_one_cycle", m.miss_pulse, 0);

        // Overlap gathered before arming is discarded; blanking overlap is ignored
        plan = 8; drive();
        while (vc == 0) tick();
        plan = 0; draw_blank = 1'b1; drive();
        m.fire = 1'b1; tick(); tick(); m.fire = 1'b0; tick(); tick();
        chk("blank_armed", m.armed, 1);
        chk("blank_shots", m.shots, 3);
        past_frame_end();
        chk("arm_clears_ovl", m.hit_pulse, 0);
        past_frame_end();
        chk("blank_ignored", m.hit_pulse, 0);
        chk("blank_still_armed", m.armed, 1);
        past_frame_end();
        chk("blank_miss", m.miss_pulse, 1);
        chk("blank_score", m.score, 1);

        // fire_rise coincides with frame_end, then exactly 4 overlaps hit
        draw_blank = 1'b0; plan = 8; drive();
        while (!(hc == 12 && vc == 7)) tick();
        m.fire = 1'b1; tick(); tick(); m.fire = 1'b0; tick();
        chk("sim_pre_armed", m.armed, 0);
        tick();
        chk("sim_armed", m.armed, 1);
        chk("sim_shots", m.shots, 4);
        plan = 4; drive();
        past_frame_end();
        chk("sim_hit", m.hit_pulse, 1);
        chk("sim_score", m.score, 2);

        // Reset in the middle of KILL
        repeat (5) tick();
        chk("pre_rst_kill", m.duck_kill, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_armed", m.armed, 0);
        chk("mid_rst_kill", m.duck_kill, 0);
        chk("mid_rst_hit", m.hit_pulse, 0);
        chk("mid_rst_miss", m.miss_pulse, 0);
        chk("mid_rst_score", m.score, 0);
        chk("mid_rst_shots", m.shots, 0);
        rst = 1'b0;
        plan = 8; drive();
        past_frame_end();
        chk("post_rst_kill", m.duck_kill, 0);
        chk("post_rst_armed", m.armed, 0);
        chk("post_rst_score", m.score, 0);
        chk("pulse_totals_hits", hits_seen, 2);
        chk("pulse_totals_misses", misses_seen, 2);
        chk("pulse_exclusive", both_seen, 0);
        plan = 0; drive();

        // Saturation: 256 hits on the small-frame instance
        for (int i = 1; i <= 256; i++) begin
            s.fire = 1'b1; tick(); tick(); s.fire = 1'b0;
            g = 0;
            while (s.hit_pulse !== 1'b1 && g < 400) begin tick(); g++; end
            if (g >= 400) begin
                sat_timeouts++;
                break;
            end
            if (i == 1) begin
                chk("sat_first_score", s.score, 1);
                chk("sat_first_shots", s.shots, 1);
            end
            if (i == 255) begin
                chk("sat_255_score", s.score, 255);
                chk("sat_255_shots", s.shots, 255);
            end
            if (i == 256) begin
                chk("sat_256_pulse", s.hit_pulse, 1);
                chk("sat_256_score", s.score, 255);
                chk("sat_256_shots", s.shots, 255);
            end
            g = 0;
            while (s.duck_kill === 1'b1 && g < 400) begin tick(); g++; end
        end
        chk("sat_timeouts", sat_timeouts, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hit_scorer.md
Name: hit_scorer

Overview:
- Scoring stage downstream of the duck, gun and shot drawers. Consumes their per-pixel draw flags and the VGA counters.
- Decides once per frame whether an armed shot overlaps the duck, and counts hits and shots.
- Drives duck_kill back to the duck drawer, which shows the falling duck.
- Its score output replaces the pos_x debug mapping on the LEDs.

Parameters:
H_TOTAL, 800, pixels per line including blanking
V_TOTAL, 525, lines per frame including blanking
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines
MIN_OVERLAP, 4, overlapping active pixels needed in one frame to score a hit
SHOT_FRAMES, 30, frames a shot stays armed before it counts as a miss
KILL_FRAMES, 60, frames duck_kill is held after a hit

Ports:
vga_clk  in  1  pixel clock (25 MHz); the only clock
reset  in  1  synchronous, active-high
hcount  in  10  horizontal pixel counter from the VGA logic
vcount  in  10  vertical line counter from the VGA logic
duck_draw  in  1  duck drawer claims the current pixel
shot_draw  in  1  shot drawer claims the current pixel
fire  in  1  raw fire button (asynchronous)
armed  out  1  a shot is in flight
hit_pulse  out  1  one-cycle pulse on a scored hit
miss_pulse  out  1  one-cycle pulse on an expired shot
duck_kill  out  1  duck is falling; level output
score  out  8  hits, saturating at 255
shots  out  8  shots fired, saturating at 255

Behaviour:
- Interface: one clock (vga_clk); reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, all counters 0, synchroniser flops 0.
- Fire conditioning:
  - fire passes through a 2-flop synchroniser, then a rising-edge detector.
  - fire_rise is asserted 3 cycles after the raw edge.
  - Held or bouncing fire counts once per low-to-high transition of the synchronised signal.
- frame_end = (hcount == H_TOTAL-1) && (vcount == V_TOTAL-1); a single-cycle strobe.
- Overlap counter (ovl, 8 bits, saturating at 255):
  - Increments when hcount < H_ACTIVE, vcount < V_ACTIVE, duck_draw and shot_draw are all true.
  - Cleared the cycle after frame_end. Also cleared on entry to ARMED; that clear overrides any increment in the same cycle.
- FSM, IDLE:
  - armed=0, duck_kill=0.
  - fire_rise -> ARMED: frame_cnt=0, ovl cleared, shots += 1 (saturating).
  - Overlap while IDLE is never scored.
- FSM, ARMED:
  - armed=1; fire_rise is ignored.
  - At frame_end with ovl >= MIN_OVERLAP -> KILL. hit_pulse=1 for that cycle; score += 1 (saturating); kill_cnt=0.
  - At frame_end with ovl below threshold and frame_cnt == SHOT_FRAMES-1 -> IDLE, miss_pulse=1 for that cycle.
  - Otherwise at frame_end, frame_cnt += 1.
  - The first frame after arming is partial; it is evaluated like any other frame.
- FSM, KILL:
  - duck_kill=1, armed=0; fire_rise is ignored.
  - At each frame_end kill_cnt += 1. When kill_cnt == KILL_FRAMES-1 at frame_end -> IDLE; duck_kill drops the next cycle.
- Latency:
  - hit_pulse, miss_pulse and the FSM transitions are registered; they are visible the cycle after frame_end.
  - score and shots update in the same cycle as the corresponding pulse or transition.
  - The pixel at (H_TOTAL-1, V_TOTAL-1) is blanking, so it never contributes to ovl.
- Simultaneous events:
  - fire_rise with frame_end in IDLE: arm. The clear-on-entry wins, so ovl ends at 0.
  - hit_pulse and miss_pulse are never asserted together.
- Saturation: at 255, score and shots hold; pulses still fire.
- Reset mid-operation (any state): return to IDLE next cycle, clear every counter, no pulse emitted.
- Counter widths: frame_cnt and kill_cnt are 8 bits; SHOT_FRAMES and KILL_FRAMES must be ≤ 256.

Decomposition:
- Shared package:
  - VGA timing constants (H_TOTAL, V_TOTAL, H_ACTIVE, V_ACTIVE), shared with VGA_LOGIC and the drawers.
  - State encoding: IDLE=2'd0, ARMED=2'd1, KILL=2'd2.
- Sub-module fire_edge_sync: 2-flop synchroniser plus rising-edge detector, reusable for izq/der.
- Everything else (FSM, ovl, frame_cnt, kill_cnt, score, shots) stays in hit_scorer.

Test Plan:
Bench uses H_TOTAL=16, V_TOTAL=8, H_ACTIVE=12, V_ACTIVE=6, MIN_OVERLAP=4, SHOT_FRAMES=3, KILL_FRAMES=2.
1. Hit: fire pulse, then 5 overlapping active pixels in the next frame -> one hit_pulse the cycle after frame_end; score=1, shots=1, duck_kill high for exactly 2 frames, then IDLE.
2. Threshold: exactly 3 overlapping pixels per frame for 3 frames -> no hit; miss_pulse after the 3rd frame_end; score=0, shots=1, armed drops.
3. Ignored fire: fire pulses while ARMED and while KILL -> shots unchanged; a fire in IDLE after KILL ends -> shots=2.
4. Overlap while IDLE: 100 overlapping pixels with no fire -> score stays 0, no pulses.
5. Simultaneous events: raw fire timed so fire_rise coincides with frame_end -> armed=1 and ovl=0; 4 overlaps in the next frame -> hit.
6. Reset and saturation: reset asserted mid-KILL -> all outputs 0 next cycle. After forcing 256 hits -> score holds at 255 while hit_pulse still fires.
